// File: rtl/store_buffer_if.sv
// store_buffer_if: groups the core store port, core load port and the
// memory port-1 write side of the store buffer into one bundle.
//   store : st_valid, st_type, st_addr, st_data -> st_ready
//   load  : ld_valid, ld_type, ld_addr -> ld_hit, ld_fwd_data, ld_stall
//   memory: mem_read_active -> mem_write_en, mem_storetype, mem_addr, mem_data
//   status: count, empty
// master = core/memory side, slave = the store buffer.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
`ifndef STORE_BYTE
`define STORE_BYTE       4'd1
`define STORE_HALFWORD   4'd2
`define STORE_WORD       4'd3
`define STORE_DOUBLEWORD 4'd4
`endif
`ifndef LOAD_BYTE
`define LOAD_BYTE         4'd1
`define LOAD_HALFWORD     4'd2
`define LOAD_WORD         4'd3
`define LOAD_DOUBLEWORD   4'd4
`define LOAD_BYTE_U       4'd5
`define LOAD_HALFWORD_U   4'd6
`endif

interface store_buffer_if #(
  parameter int unsigned PTR_W = 2
);
  logic                  st_valid;
  logic [3:0]            st_type;
  logic [`BIT_WIDTH-1:0] st_addr;
  logic [`BIT_WIDTH-1:0] st_data;
  logic                  st_ready;
  logic                  ld_valid;
  logic [3:0]            ld_type;
  logic [`BIT_WIDTH-1:0] ld_addr;
  logic                  ld_hit;
  logic [`BIT_WIDTH-1:0] ld_fwd_data;
  logic                  ld_stall;
  logic                  mem_read_active;
  logic                  mem_write_en;
  logic [3:0]            mem_storetype;
  logic [`BIT_WIDTH-1:0] mem_addr;
  logic [`BIT_WIDTH-1:0] mem_data;
  logic [PTR_W:0]        count;
  logic                  empty;

  modport master (
    output st_valid, st_type, st_addr, st_data,
    output ld_valid, ld_type, ld_addr, mem_read_active,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall,
    input  mem_write_en, mem_storetype, mem_addr, mem_data, count, empty
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data,
    input  ld_valid, ld_type, ld_addr, mem_read_active,
    output st_ready, ld_hit, ld_fwd_data, ld_stall,
    output mem_write_en, mem_storetype, mem_addr, mem_data, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order write-back store queue in front of data memory
// port 1. Drains the oldest entry per cycle when the port is not reading,
// and checks each load against all pending stores (queued + in flight),
// forwarding on an exact-address, large-enough match and stalling otherwise.
// Ports:
//   clock - sole clock (posedge)
//   rst   - asynchronous active-high reset
//   bus   - store_buffer_if.slave (store, load, memory and status signals)
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
`ifndef STORE_BYTE
`define STORE_BYTE       4'd1
`define STORE_HALFWORD   4'd2
`define STORE_WORD       4'd3
`define STORE_DOUBLEWORD 4'd4
`endif
`ifndef LOAD_BYTE
`define LOAD_BYTE         4'd1
`define LOAD_HALFWORD     4'd2
`define LOAD_WORD         4'd3
`define LOAD_DOUBLEWORD   4'd4
`define LOAD_BYTE_U       4'd5
`define LOAD_HALFWORD_U   4'd6
`endif

module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic           clock,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int unsigned BW = `BIT_WIDTH;
  localparam int unsigned MB = `MEMORY_BITS;
  localparam int unsigned AW = MB + 1;
  localparam int unsigned CW = PTR_W + 1;

  logic [3:0]    entType [DEPTH];
  logic [BW-1:0] entAddr [DEPTH];
  logic [BW-1:0] entData [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CW-1:0]    cnt;
  logic             memWe;
  logic [3:0]       memType;
  logic [BW-1:0]    memAddr, memData;

  logic doPush, doPop;
  logic hit, stall;
  logic [BW-1:0] fwdData;
  logic unusedLdAddr;

  function automatic logic [3:0] storeSize(input logic [3:0] t);
    case (t)
      `STORE_BYTE:       return 4'd1;
      `STORE_HALFWORD:   return 4'd2;
      `STORE_WORD:       return 4'd4;
      `STORE_DOUBLEWORD: return 4'd8;
      default:           return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] loadSize(input logic [3:0] t);
    case (t)
      `LOAD_BYTE, `LOAD_BYTE_U:         return 4'd1;
      `LOAD_HALFWORD, `LOAD_HALFWORD_U: return 4'd2;
      `LOAD_WORD:                       return 4'd4;
      `LOAD_DOUBLEWORD:                 return 4'd8;
      default:                          return 4'd0;
    endcase
  endfunction

  // Same extension the memory applies on its read path.
  function automatic logic [BW-1:0] extend(input logic [BW-1:0] d, input logic [3:0] t);
    case (t)
      `LOAD_BYTE:       return {{(BW-8){d[7]}}, d[7:0]};
      `LOAD_HALFWORD:   return {{(BW-16){d[15]}}, d[15:0]};
      `LOAD_WORD:       return {{(BW-32){d[31]}}, d[31:0]};
      `LOAD_DOUBLEWORD: return d;
      `LOAD_BYTE_U:     return {{(BW-8){1'b0}}, d[7:0]};
      `LOAD_HALFWORD_U: return {{(BW-16){1'b0}}, d[15:0]};
      default:          return '0;
    endcase
  endfunction

  // Byte-range intersection on truncated addresses; one extra bit so ends never wrap.
  function automatic logic overlaps(input logic [BW-1:0] ca, input logic [3:0] cs,
                                    input logic [AW-1:0] lLo, input logic [AW-1:0] lHi);
    logic [AW-1:0] cLo, cHi;
    cLo = AW'(ca[MB-1:0]);
    cHi = cLo + AW'(cs);
    return (lLo < cHi) && (cLo < lHi);
  endfunction

  assign bus.st_ready = cnt < CW'(DEPTH);
  assign doPush = bus.st_valid && bus.st_ready && (storeSize(bus.st_type) != 4'd0);
  assign doPop  = (cnt != '0) && !bus.mem_read_active;

  // Queue storage, pointers and the in-flight output stage.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      memWe   <= 1'b0;
      memType <= '0;
      memAddr <= '0;
      memData <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entType[i] <= '0;
        entAddr[i] <= '0;
        entData[i] <= '0;
      end
    end else begin
      if (doPush) begin
        entType[tail] <= bus.st_type;
        entAddr[tail] <= bus.st_addr;
        entData[tail] <= bus.st_data;
        tail          <= tail + 1'b1;
      end
      if (doPop) begin
        memWe   <= 1'b1;
        memType <= entType[head];
        memAddr <= entAddr[head];
        memData <= entData[head];
        head    <= head + 1'b1;
      end else begin
        memWe <= 1'b0;
      end
      cnt <= cnt + CW'(doPush) - CW'(doPop);
    end
  end

  // Load check: scan oldest (in flight) to youngest so the last overlap wins.
  always_comb begin
    logic [3:0]       ldSize;
    logic [AW-1:0]    ldLo, ldHi;
    logic             found;
    logic [3:0]       eType;
    logic [MB-1:0]    eAddr;
    logic [BW-1:0]    eData;
    logic [PTR_W-1:0] idx;
    ldSize  = loadSize(bus.ld_type);
    ldLo    = AW'(bus.ld_addr[MB-1:0]);
    ldHi    = ldLo + AW'(ldSize);
    found   = 1'b0;
    eType   = '0;
    eAddr   = '0;
    eData   = '0;
    idx     = '0;
    hit     = 1'b0;
    stall   = 1'b0;
    fwdData = '0;
    if (memWe && overlaps(memAddr, storeSize(memType), ldLo, ldHi)) begin
      found = 1'b1;
      eType = memType;
      eAddr = memAddr[MB-1:0];
      eData = memData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CW'(i) < cnt) && overlaps(entAddr[idx], storeSize(entType[idx]), ldLo, ldHi)) begin
        found = 1'b1;
        eType = entType[idx];
        eAddr = entAddr[idx][MB-1:0];
        eData = entData[idx];
      end
    end
    if (bus.ld_valid && (ldSize != 4'd0) && found) begin
      if ((eAddr == bus.ld_addr[MB-1:0]) && (storeSize(eType) >= ldSize)) begin
        hit     = 1'b1;
        fwdData = extend(eData, bus.ld_type);
      end else begin
        stall = 1'b1;
      end
    end
  end

  // Address bits above the memory size never take part in the compare.
  assign unusedLdAddr = ^bus.ld_addr[BW-1:MB];

  assign bus.ld_hit        = hit;
  assign bus.ld_stall      = stall;
  assign bus.ld_fwd_data   = fwdData;
  assign bus.mem_write_en  = memWe;
  assign bus.mem_storetype = memType;
  assign bus.mem_addr      = memAddr;
  assign bus.mem_data      = memData;
  assign bus.count         = cnt;
  assign bus.empty         = (cnt == '0) && !memWe;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer. Expected memory writes
// are queued when a store is driven and checked as the DUT issues them.
`ifndef BIT_WIDTH
`define BIT_WIDTH 64
`endif
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
`ifndef STORE_BYTE
`define STORE_BYTE       4'd1
`define STORE_HALFWORD   4'd2
`define STORE_WORD       4'd3
`define STORE_DOUBLEWORD 4'd4
`endif
`ifndef LOAD_BYTE
`define LOAD_BYTE         4'd1
`define LOAD_HALFWORD     4'd2
`define LOAD_WORD         4'd3
`define LOAD_DOUBLEWORD   4'd4
`define LOAD_BYTE_U       4'd5
`define LOAD_HALFWORD_U   4'd6
`endif

module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  store_buffer_if #(.PTR_W(PTR_W)) bus ();
  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clock(clock), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  t;
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t sb[$];
  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; any write issued this cycle is matched against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (bus.mem_write_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(bus.mem_write_en), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e.a);
        chk("wr_type", 64'(bus.mem_storetype), 64'(e.t));
        chk("wr_data", bus.mem_data, e.d);
      end
    end
  endtask

  task automatic push_st(input logic [3:0] t, input logic [63:0] a, input logic [63:0] d,
                         input bit acc);
    wr_t e;
    bus.st_valid = 1'b1;
    bus.st_type  = t;
    bus.st_addr  = a;
    bus.st_data  = d;
    if (acc) begin
      e.t = t;
      e.a = a;
      e.d = d;
      sb.push_back(e);
    end
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic ld_chk(input string tag, input logic [3:0] t, input logic [63:0] a,
                        input logic h, input logic s, input logic [63:0] f, input bit cd);
    bus.ld_valid = 1'b1;
    bus.ld_type  = t;
    bus.ld_addr  = a;
    #1;
    chk({tag, "_hit"}, 64'(bus.ld_hit), 64'(h));
    chk({tag, "_stall"}, 64'(bus.ld_stall), 64'(s));
    if (cd) chk({tag, "_data"}, bus.ld_fwd_data, f);
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    bus.st_valid = 1'b0; bus.st_type = '0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_type = '0; bus.ld_addr = '0;
    bus.mem_read_active = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_we", 64'(bus.mem_write_en), 64'd0);
    chk("rst_addr", bus.mem_addr, 64'd0);
    chk("rst_data", bus.mem_data, 64'd0);
    chk("rst_type", 64'(bus.mem_storetype), 64'd0);
    chk("rst_hit", 64'(bus.ld_hit), 64'd0);
    chk("rst_stall", 64'(bus.ld_stall), 64'd0);
    chk("rst_fwd", bus.ld_fwd_data, 64'd0);
    rst = 1'b0;

    // Illegal store code is dropped
    push_st(4'hF, 64'h80, 64'h55, 1'b0);
    chk("illegal_st_count", 64'(bus.count), 64'd0);
    tick();
    chk("illegal_st_we", 64'(bus.mem_write_en), 64'd0);

    // Drain latency
    push_st(`STORE_DOUBLEWORD, 64'h10, 64'h1122334455667788, 1'b1);
    chk("lat_count_T", 64'(bus.count), 64'd1);
    chk("lat_we_T", 64'(bus.mem_write_en), 64'd0);
    chk("lat_empty_T", 64'(bus.empty), 64'd0);
    tick();
    chk("lat_we_T1", 64'(bus.mem_write_en), 64'd1);
    chk("lat_count_T1", 64'(bus.count), 64'd0);
    tick();
    chk("lat_we_T2", 64'(bus.mem_write_en), 64'd0);
    chk("lat_empty_T2", 64'(bus.empty), 64'd1);

    // Fill under a busy port
    bus.mem_read_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_st_ready", 64'(bus.st_ready), 64'(i < 4));
      push_st(`STORE_WORD, 64'h100 + 64'(8 * i), 64'hA0 + 64'(i), i < 4);
    end
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_st_ready_full", 64'(bus.st_ready), 64'd0);
    bus.mem_read_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_drain_we", 64'(bus.mem_write_en), 64'd1);
    end
    tick();
    chk("fill_done_we", 64'(bus.mem_write_en), 64'd0);
    chk("fill_done_empty", 64'(bus.empty), 64'd1);
    chk("fill_writes_left", 64'(sb.size()), 64'd0);

    // Forwarding from a queued word
    bus.mem_read_active = 1'b1;
    push_st(`STORE_WORD, 64'h20, 64'h80000001, 1'b1);
    ld_chk("fw_lb", `LOAD_BYTE, 64'h20, 1'b1, 1'b0, 64'h1, 1'b1);
    ld_chk("fw_lw", `LOAD_WORD, 64'h20, 1'b1, 1'b0, 64'hFFFFFFFF80000001, 1'b1);
    ld_chk("fw_lhu", `LOAD_HALFWORD_U, 64'h20, 1'b1, 1'b0, 64'h1, 1'b1);
    ld_chk("fw_ld_too_big", `LOAD_DOUBLEWORD, 64'h20, 1'b0, 1'b1, 64'h0, 1'b0);
    ld_chk("fw_lb_past_end", `LOAD_BYTE, 64'h24, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    ld_chk("fw_illegal_ld", 4'hF, 64'h20, 1'b0, 1'b0, 64'h0, 1'b1);
    ld_chk("fw_lw_hiaddr", `LOAD_WORD, 64'h0001_0000_0000_0020, 1'b1, 1'b0, 64'hFFFFFFFF80000001, 1'b1);
    bus.mem_read_active = 1'b0;
    tick();
    ld_chk("fw_lw_inflight", `LOAD_WORD, 64'h20, 1'b1, 1'b0, 64'hFFFFFFFF80000001, 1'b1);
    tick();
    ld_chk("fw_lw_gone", `LOAD_WORD, 64'h20, 1'b0, 1'b0, 64'h0, 1'b0);

    // Youngest overlapping store wins
    bus.mem_read_active = 1'b1;
    push_st(`STORE_BYTE, 64'h30, 64'hAA, 1'b1);
    push_st(`STORE_BYTE, 64'h30, 64'hBB, 1'b1);
    ld_chk("yw_lbu", `LOAD_BYTE_U, 64'h30, 1'b1, 1'b0, 64'hBB, 1'b1);
    ld_chk("yw_lb", `LOAD_BYTE, 64'h30, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFBB, 1'b1);
    ld_chk("yw_lh_stall", `LOAD_HALFWORD, 64'h30, 1'b0, 1'b1, 64'h0, 1'b0);
    bus.mem_read_active = 1'b0;
    tick();
    ld_chk("yw_lbu_aa_inflight", `LOAD_BYTE_U, 64'h30, 1'b1, 1'b0, 64'hBB, 1'b1);
    tick();
    ld_chk("yw_lbu_bb_inflight", `LOAD_BYTE_U, 64'h30, 1'b1, 1'b0, 64'hBB, 1'b1);
    tick();
    ld_chk("yw_drained", `LOAD_BYTE_U, 64'h30, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("yw_empty", 64'(bus.empty), 64'd1);

    // Partial overlap stalls until the write edge has passed
    bus.mem_read_active = 1'b1;
    push_st(`STORE_BYTE, 64'h41, 64'h7F, 1'b1);
    ld_chk("po_lw", `LOAD_WORD, 64'h40, 1'b0, 1'b1, 64'h0, 1'b0);
    ld_chk("po_lb_exact", `LOAD_BYTE, 64'h41, 1'b1, 1'b0, 64'h7F, 1'b1);
    ld_chk("po_lb_below", `LOAD_BYTE, 64'h40, 1'b0, 1'b0, 64'h0, 1'b0);
    ld_chk("po_lh_above", `LOAD_HALFWORD, 64'h42, 1'b0, 1'b0, 64'h0, 1'b0);
    ld_chk("po_lh_cover", `LOAD_HALFWORD, 64'h40, 1'b0, 1'b1, 64'h0, 1'b0);
    tick();
    ld_chk("po_lw_held", `LOAD_WORD, 64'h40, 1'b0, 1'b1, 64'h0, 1'b0);
    bus.mem_read_active = 1'b0;
    tick();
    chk("po_inflight_we", 64'(bus.mem_write_en), 64'd1);
    ld_chk("po_lw_inflight", `LOAD_WORD, 64'h40, 1'b0, 1'b1, 64'h0, 1'b0);
    tick();
    ld_chk("po_lw_clear", `LOAD_WORD, 64'h40, 1'b0, 1'b0, 64'h0, 1'b0);

    // Asynchronous reset with one in flight and three queued
    bus.mem_read_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_st(`STORE_DOUBLEWORD, 64'h200 + 64'(8 * i), 64'hC0DE0000 + 64'(i), 1'b1);
    end
    chk("ar_count_full", 64'(bus.count), 64'd4);
    bus.mem_read_active = 1'b0;
    tick();
    chk("ar_inflight_we", 64'(bus.mem_write_en), 64'd1);
    chk("ar_count_3", 64'(bus.count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_we", 64'(bus.mem_write_en), 64'd0);
    chk("ar_count", 64'(bus.count), 64'd0);
    chk("ar_empty", 64'(bus.empty), 64'd1);
    chk("ar_st_ready", 64'(bus.st_ready), 64'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_no_write", 64'(bus.mem_write_en), 64'd0);
    end
    chk("end_writes_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
